// File: rtl/bitbakery_serial_tx.sv
// Free-running UART 8N1 transmitter: repeatedly sends the shadowed bytes D0..D3 as one
// packet, followed by GAP_BITS idle bit periods.
module bitbakery_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned GAP_BITS     = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] D0,
  input  logic [7:0] D1,
  input  logic [7:0] D2,
  input  logic [7:0] D3,
  output logic       saida_serial
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GapLast = GW'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

  localparam logic [2:0] StPre   = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StGap   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          line_q, line_d;

  logic [7:0] cur_byte;
  logic [2:0] next_bit;
  logic       bit_done;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    shadow_d   = shadow_q;
    line_d     = line_q;
    cur_byte   = shadow_q[{byte_idx_q, 3'b000} +: 8];
    next_bit   = bit_idx_q + 3'd1;
    bit_done   = (cnt_q == CntLast);

    // The counter only runs once a bit is on the line; the pre-start state lasts one edge.
    if (state_q != StPre) begin
      cnt_d = bit_done ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      StPre: begin
        state_d    = StStart;
        byte_idx_d = 2'd0;
        shadow_d   = {D3, D2, D1, D0};
        line_d     = 1'b0;
      end
      StStart: begin
        if (bit_done) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
          line_d    = cur_byte[0];
        end
      end
      StData: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            line_d  = 1'b1;
          end else begin
            bit_idx_d = next_bit;
            line_d    = cur_byte[next_bit];
          end
        end
      end
      StStop: begin
        if (bit_done) begin
          if (byte_idx_q != 2'd3) begin
            state_d    = StStart;
            byte_idx_d = byte_idx_q + 2'd1;
            line_d     = 1'b0;
          end else if (GAP_BITS == 0) begin
            state_d    = StStart;
            byte_idx_d = 2'd0;
            shadow_d   = {D3, D2, D1, D0};
            line_d     = 1'b0;
          end else begin
            state_d   = StGap;
            gap_cnt_d = '0;
            line_d    = 1'b1;
          end
        end
      end
      StGap: begin
        if (bit_done) begin
          if (gap_cnt_q == GapLast) begin
            state_d    = StStart;
            byte_idx_d = 2'd0;
            shadow_d   = {D3, D2, D1, D0};
            line_d     = 1'b0;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StPre;
        line_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StPre;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      gap_cnt_q  <= '0;
      shadow_q   <= '0;
      line_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      shadow_q   <= shadow_d;
      line_q     <= line_d;
    end
  end

  assign saida_serial = line_q;

endmodule

// File: tb/tb_bitbakery_serial_tx.sv
// Scoreboard bench: three transmitters (4/2, 4/0 and default 434/10) share inputs; each line
// is decoded into frames and compared with bytes predicted from packet-start arithmetic.
module tb_bitbakery_serial_tx;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d0, d1, d2, d3;
  logic [2:0] line;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int rel_cyc = 0;

  // Expected frames per DUT: {last_of_packet, byte}.
  logic [8:0] exp_q [3][$];

  bitbakery_serial_tx #(.CLKS_PER_BIT(4), .GAP_BITS(2)) dut_a (
    .clock(clock), .reset(rst_n), .D0(d0), .D1(d1), .D2(d2), .D3(d3), .saida_serial(line[0])
  );
  bitbakery_serial_tx #(.CLKS_PER_BIT(4), .GAP_BITS(0)) dut_b (
    .clock(clock), .reset(rst_n), .D0(d0), .D1(d1), .D2(d2), .D3(d3), .saida_serial(line[1])
  );
  bitbakery_serial_tx dut_c (
    .clock(clock), .reset(rst_n), .D0(d0), .D1(d1), .D2(d2), .D3(d3), .saida_serial(line[2])
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int clk_of(input int i);
    return (i == 2) ? 434 : 4;
  endfunction

  function automatic int gap_of(input int i);
    case (i)
      0:       return 2;
      1:       return 0;
      default: return 10;
    endcase
  endfunction

  function automatic int period_of(input int i);
    return (40 + gap_of(i)) * clk_of(i);
  endfunction

  task automatic push_pkt(input int i);
    exp_q[i].push_back({1'b0, d0});
    exp_q[i].push_back({1'b0, d1});
    exp_q[i].push_back({1'b0, d2});
    exp_q[i].push_back({1'b1, d3});
  endtask

  task automatic step(input bit rnd);
    @(posedge clock);
    #1;
    if (rnd && $urandom_range(7) == 0) begin
      case ($urandom_range(3))
        0:       d0 = 8'($urandom);
        1:       d1 = 8'($urandom);
        2:       d2 = 8'($urandom);
        default: d3 = 8'($urandom);
      endcase
    end
    // Values present now are captured by the edge that begins packet k.
    for (int i = 0; i < 3; i++) begin
      if ((cyc - rel_cyc) % period_of(i) == 0) push_pkt(i);
    end
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    rel_cyc = cyc;
    rst_n   = 1'b1;
    for (int i = 0; i < 3; i++) push_pkt(i);
  endtask

  // Monitor: frames are 10 bit periods; every cycle of each bit must match its first sample.
  logic       busy   [3];
  logic       first  [3];
  logic       stable [3];
  logic       plast  [3];
  logic [9:0] fbits  [3];
  logic [8:0] cur    [3];
  int         pos    [3];
  int         pstart [3];
  int         nframe [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      busy[i] = 1'b0; first[i] = 1'b1; nframe[i] = 0; plast[i] = 1'b0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          busy[i] = 1'b0; first[i] = 1'b1; nframe[i] = 0;
          nchk++;
          if (line[i] !== 1'b1) begin
            nerr++;
            $display("FAIL reset_idle dut%0d: line=%b required 1", i, line[i]);
          end
        end else begin
          if (!busy[i] && line[i] === 1'b0) begin
            int exp_start;
            exp_start = first[i] ? rel_cyc + 1
                      : pstart[i] + (plast[i] ? (10 + gap_of(i)) * clk_of(i) : 10 * clk_of(i));
            nchk++;
            if (cyc != exp_start) begin
              nerr++;
              $display("FAIL frame_start dut%0d: cycle=%0d required %0d", i, cyc, exp_start);
            end
            busy[i] = 1'b1; pos[i] = 0; stable[i] = 1'b1; first[i] = 1'b0; pstart[i] = cyc;
            if (exp_q[i].size() == 0) begin
              nchk++; nerr++;
              $display("FAIL underflow dut%0d: frame with no expected byte", i);
              cur[i] = 9'h000;
            end else begin
              cur[i] = exp_q[i].pop_front();
            end
            plast[i] = cur[i][8];
          end
          if (busy[i]) begin
            int b;
            b = pos[i] / clk_of(i);
            if (pos[i] % clk_of(i) == 0) fbits[i][b] = line[i];
            else if (line[i] !== fbits[i][b]) stable[i] = 1'b0;
            pos[i]++;
            if (pos[i] == 10 * clk_of(i)) begin
              busy[i] = 1'b0;
              nframe[i]++;
              nchk++;
              if (fbits[i][8:1] !== cur[i][7:0]) begin
                nerr++;
                $display("FAIL frame_data dut%0d: got %02h required %02h", i, fbits[i][8:1],
                         cur[i][7:0]);
              end
              nchk++;
              if ({fbits[i][0], fbits[i][9], stable[i]} !== 3'b011) begin
                nerr++;
                $display("FAIL frame_shape dut%0d: start/stop/stable=%b required 011", i,
                         {fbits[i][0], fbits[i][9], stable[i]});
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int guard;
    d0 = 8'h35; d1 = 8'h4A; d2 = 8'h90; d3 = 8'hC0;
    rst_n = 1'b0;
    repeat (4) @(posedge clock);
    release_reset();

    // D1 changes while byte 0 is on the line: only the next packet may carry it.
    repeat (5) step(1'b0);
    d1 = 8'h7F;
    repeat (2 * 168) step(1'b0);
    repeat (3 * 168) step(1'b1);

    // Abort during data bit 3 of byte 2 on the 4/2 instance.
    guard = 0;
    while ((cyc + 1 - rel_cyc) % 168 != 98 && guard < 200) begin
      step(1'b1);
      guard++;
    end
    @(posedge clock);
    #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      nchk++;
      if (line[i] !== 1'b1) begin
        nerr++;
        $display("FAIL async_reset dut%0d: line=%b required 1", i, line[i]);
      end
      exp_q[i].delete();
    end
    repeat (3) @(posedge clock);
    release_reset();
    repeat (44000) step(1'b1);

    for (int i = 0; i < 3; i++) begin
      nchk++;
      if (nframe[i] < 8) begin
        nerr++;
        $display("FAIL frame_count dut%0d: frames=%0d required >= 8", i, nframe[i]);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/bitbakery_serial_tx.md
BITBAKERY_SERIAL_TX -- requirements
Module: bitbakery_serial_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434: clock cycles per serial bit (50 MHz / 115200 baud); legal range >= 2.
REQ-002 The block SHALL have parameter GAP_BITS, default 10: idle (line-high) bit periods inserted after each 4-byte packet; legal range >= 0.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock (50 MHz system clock, not divided); all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port D0, input, 8 bits: packet byte 0.
REQ-006 The block SHALL have port D1, input, 8 bits: packet byte 1.
REQ-007 The block SHALL have port D2, input, 8 bits: packet byte 2.
REQ-008 The block SHALL have port D3, input, 8 bits: packet byte 3.
REQ-009 The block SHALL have port saida_serial, output, 1 bit: UART TX line, idle high.

Function
REQ-010 The block SHALL transmit D0, D1, D2, D3 continuously and repeatedly, in that order, as UART 8N1 frames: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-011 Each bit, including start, data, stop and gap bits, SHALL be held on saida_serial for exactly CLKS_PER_BIT clock cycles.
REQ-012 saida_serial SHALL be driven directly from a flip-flop, with no combinational path from D0-D3.
REQ-013 The four frames of a packet SHALL be back-to-back: the start bit of byte n+1 immediately follows the stop bit of byte n.
REQ-014 After the stop bit of D3, the line SHALL stay at 1 for GAP_BITS bit periods; the next packet then starts with no further delay.
REQ-015 The packet period SHALL be exactly (40 + GAP_BITS) × CLKS_PER_BIT cycles.
REQ-016 At the rising edge where a packet's first start bit begins, the block SHALL latch D0-D3 into internal shadow registers.
REQ-017 All four frames of a packet SHALL use the shadow values; changes on D0-D3 during a packet appear only in the next packet.
REQ-018 The state machine SHALL have the states START, DATA (with 3-bit bit index 0-7), STOP and GAP.
REQ-019 The state machine SHALL keep a 2-bit byte index 0-3 that wraps from 3 to 0 after GAP.
REQ-020 State transitions: START→DATA, DATA(7)→STOP, STOP→START if byte index < 3, otherwise STOP→GAP (or →START with byte index 0 if GAP_BITS = 0), and GAP→START when GAP completes.
REQ-021 The bit-time counter SHALL count 0 to CLKS_PER_BIT−1, and state or bit advances SHALL occur only on its terminal count.
REQ-022 The counter width SHALL be sized from CLKS_PER_BIT, with no overflow for any legal value.
REQ-023 The block SHALL have no handshake or enable; transmission is free-running.

Reset
REQ-024 While reset = 0, saida_serial SHALL be 1 immediately (asynchronously) and the counter, bit index, byte index and shadow registers SHALL be 0.
REQ-025 The FSM SHALL be held in a pre-start state while reset = 0.
REQ-026 At the first rising edge with reset = 1, the block SHALL latch D0-D3 and drive the start bit (0) of byte 0.
REQ-027 If reset is asserted mid-frame or mid-gap, the partial frame SHALL be abandoned and no glitch low may follow.
REQ-028 After a reset mid-frame or mid-gap, transmission SHALL restart from byte 0 per REQ-026.

Verification
REQ-029 Scenario: CLKS_PER_BIT=4, GAP_BITS=2, D0=0x35, D1=0x4A, D2=0x90, D3=0xC0, reset released → line decodes 0x35, 0x4A, 0x90, 0xC0 LSB first; byte 0 bits are 0,1,0,1,0,1,1,0,0,1 (start, data, stop), each 4 cycles; 8 high cycles follow; next packet starts at cycle 168.
REQ-030 Scenario: during reset = 0 → saida_serial = 1 constantly; first 0 appears in the cycle after the first rising edge following release.
REQ-031 Scenario: change D1 from 0x4A to 0x7F while byte 0 is being sent → current packet still sends 0x4A, next packet sends 0x7F.
REQ-032 Scenario: assert reset during data bit 3 of byte 2 → saida_serial = 1 asynchronously; after release the first decoded byte is D0.
REQ-033 Scenario: GAP_BITS=0 → stop bit of D3 is followed directly by the start bit of D0; period = 160 cycles at CLKS_PER_BIT=4.
REQ-034 Scenario: defaults (434, 10) → each bit lasts exactly 434 cycles; packet period is 21700 cycles.
